cim_row_seq: RTL and testbench

- Clocked, parametrised successor to the combinational row decoder of the CIM SRAM macro.
- Accepts one operation per handshake: write, read or bit-serial MAC.
- Drives the macro's WL/WLB rows with timed pulses, separated by precharge gaps.
- For MAC, streams a multi-bit input vector MSB-first, one bit plane per pulse, and strobes the column ADC after each plane.

---
 rtl/cim_row_seq.sv | 181 ++++++++++++++++++
 tb/tb_cim_row_seq.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_row_seq.sv
// Clocked wordline sequencer for the CIM SRAM macro: WRITE/READ single pulse, bit-serial MAC planes.
// Optional MAC zero-plane skipping is enabled by defining CIM_ROW_ZSKIP_EN (adds the bit_skip port).
module cim_row_seq #(
  parameter int ADDR_W    = 2,
  parameter int IN_BITS   = 4,
  parameter int PULSE_CYC = 2,
  parameter int PRE_CYC   = 1,
  localparam int ROWS  = 2**ADDR_W,
  localparam int BIT_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    CS,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic                    MAC_en,
  input  logic                    read_bar,
  input  logic                    w_en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [ROWS*IN_BITS-1:0] data,
  output logic [ROWS-1:0]         WL,
  output logic [ROWS-1:0]         WLB,
  output logic                    bit_valid,
  output logic [BIT_W-1:0]        bit_idx,
  output logic                    done,
  output logic                    err
`ifdef CIM_ROW_ZSKIP_EN
  ,output logic                   bit_skip
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {M_WRITE, M_READ, M_MAC, M_ILLEGAL} mode_t;

  localparam int CNT_MAX = (PULSE_CYC > PRE_CYC) ? PULSE_CYC : PRE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                  state_q, state_d;
  mode_t                   mode_q, mode_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ROWS*IN_BITS-1:0] data_q, data_d;
  logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ROWS-1:0]         wl_q, wl_d;
  logic                    err_q, err_d;

  logic accept;
  logic last_plane;
  logic plane_skip;

  // Bit `idx` of every row's input word, i.e. one MAC bit plane across the rows.
  function automatic logic [ROWS-1:0] plane_of(input logic [ROWS*IN_BITS-1:0] d,
                                               input logic [BIT_W-1:0] idx);
    logic [ROWS-1:0]    p;
    logic [IN_BITS-1:0] word;
    p = '0;
    for (int r = 0; r < ROWS; r++) begin
      word = d[r*IN_BITS +: IN_BITS];
      p[r] = word[idx];
    end
    return p;
  endfunction

  function automatic mode_t decode(input logic mac, input logic we, input logic rb);
    if ((mac && we) || (we && !rb)) return M_ILLEGAL;
    if (mac) return M_MAC;
    if (we)  return M_WRITE;
    if (!rb) return M_READ;
    return M_ILLEGAL;
  endfunction

  assign op_ready   = (state_q == S_IDLE);
  assign accept     = op_valid && CS && op_ready;
  assign last_plane = (bit_idx_q == '0);

`ifdef CIM_ROW_ZSKIP_EN
  logic [ROWS-1:0] cur_plane;
  assign cur_plane  = plane_of(data_q, bit_idx_q);
  assign plane_skip = (mode_q == M_MAC) && (cur_plane == '0);
  assign bit_skip   = (state_q == S_PULSE) && plane_skip;
`else
  assign plane_skip = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    data_d    = data_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d    = decode(MAC_en, w_en, read_bar);
          addr_d    = addr;
          data_d    = data;
          cnt_d     = '0;
          bit_idx_d = (mode_d == M_MAC) ? BIT_W'(IN_BITS - 1) : '0;
          if (mode_d == M_ILLEGAL) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_PULSE;
            err_d   = 1'b0;
          end
        end
      end
      S_PULSE: begin
        // A skipped plane takes one PULSE cycle and goes straight to the next plane.
        if (plane_skip) begin
          cnt_d = '0;
          if (last_plane) begin
            state_d = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q - BIT_W'(1);
          end
        end else if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(PRE_CYC - 1)) begin
          cnt_d = '0;
          if ((mode_q == M_MAC) && !last_plane) begin
            state_d   = S_PULSE;
            bit_idx_d = bit_idx_q - BIT_W'(1);
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // WL is computed from next-state values so the registered output lines up with PULSE.
    wl_d = '0;
    if (state_d == S_PULSE) begin
      if (mode_d == M_MAC) wl_d = plane_of(data_d, bit_idx_d);
      else                 wl_d[addr_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= M_WRITE;
      addr_q    <= '0;
      data_q    <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      wl_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      wl_q      <= wl_d;
      err_q     <= err_d;
    end
  end

  assign WL        = wl_q;
  assign WLB       = ~wl_q;
  assign bit_idx   = bit_idx_q;
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign bit_valid = (state_q == S_PULSE) && (mode_q == M_MAC) &&
                     (plane_skip || (cnt_q == CNT_W'(PULSE_CYC - 1)));

endmodule

// File: tb/tb_cim_row_seq.sv
// Self-checking bench for cim_row_seq: directed scenarios plus randomized ops against a trace model.
module tb_cim_row_seq;

  localparam int ROWS    = 4;
  localparam int IN_BITS = 4;
  localparam int PC      = 2;
  localparam int PR      = 1;
`ifdef CIM_ROW_ZSKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CS = 1'b0, op_valid = 1'b0, MAC_en = 1'b0, read_bar = 1'b1, w_en = 1'b0;
  logic [1:0]  addr = '0;
  logic [15:0] data = '0;
  logic        op_ready, bit_valid, done, err;
  logic [3:0]  WL, WLB;
  logic [1:0]  bit_idx;
`ifdef CIM_ROW_ZSKIP_EN
  logic        bit_skip;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] wl;
    logic       bv;
    logic [1:0] bi;
    logic       dn;
    logic       sk;
  } exp_t;
  exp_t exp_q[$];

  cim_row_seq dut (
    .clk(clk), .rst_n(rst_n), .CS(CS), .op_valid(op_valid), .op_ready(op_ready),
    .MAC_en(MAC_en), .read_bar(read_bar), .w_en(w_en), .addr(addr), .data(data),
    .WL(WL), .WLB(WLB), .bit_valid(bit_valid), .bit_idx(bit_idx), .done(done), .err(err)
`ifdef CIM_ROW_ZSKIP_EN
    , .bit_skip(bit_skip)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present an op in one cycle, then scramble every input so latching is exercised.
  task automatic issue_op(input logic mac, input logic we, input logic rb,
                          input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    CS = 1'b1; op_valid = 1'b1; MAC_en = mac; w_en = we; read_bar = rb; addr = a; data = d;
    @(posedge clk);
    #1;
    op_valid = 1'b0; CS = 1'($urandom); MAC_en = 1'($urandom); w_en = 1'($urandom);
    read_bar = 1'($urandom); addr = 2'($urandom); data = 16'($urandom);
  endtask

  // Expected per-cycle trace from T+1 to the done cycle, built from the operation rules.
  task automatic model_op(input logic mac, input logic we, input logic rb,
                          input logic [1:0] a, input logic [15:0] d, output logic ill);
    logic [3:0] pat;
    exp_q.delete();
    ill = (mac && we) || (we && !rb) || (!mac && !we && rb);
    if (!ill) begin
      if (!mac) begin
        pat = 4'b0001 << a;
        for (int c = 0; c < PC; c++) exp_q.push_back('{wl: pat, bv: 1'b0, bi: 2'd0, dn: 1'b0, sk: 1'b0});
        for (int c = 0; c < PR; c++) exp_q.push_back('{wl: 4'b0, bv: 1'b0, bi: 2'd0, dn: 1'b0, sk: 1'b0});
      end else begin
        for (int b = IN_BITS - 1; b >= 0; b--) begin
          for (int r = 0; r < ROWS; r++) pat[r] = d[r*IN_BITS + b];
          if (ZSKIP && pat == 4'b0) begin
            exp_q.push_back('{wl: 4'b0, bv: 1'b1, bi: 2'(b), dn: 1'b0, sk: 1'b1});
          end else begin
            for (int c = 0; c < PC; c++)
              exp_q.push_back('{wl: pat, bv: (c == PC - 1), bi: 2'(b), dn: 1'b0, sk: 1'b0});
            for (int c = 0; c < PR; c++)
              exp_q.push_back('{wl: 4'b0, bv: 1'b0, bi: 2'(b), dn: 1'b0, sk: 1'b0});
          end
        end
      end
    end
    exp_q.push_back('{wl: 4'b0, bv: 1'b0, bi: 2'd0, dn: 1'b1, sk: 1'b0});
  endtask

  task automatic test_reset;
    #12;
    n_checks++; if (WL !== 4'b0)     begin n_fail++; $display("FAIL reset_wl: got %b want 0000", WL); end
    n_checks++; if (WLB !== 4'b1111) begin n_fail++; $display("FAIL reset_wlb: got %b want 1111", WLB); end
    n_checks++; if (bit_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bit_idx !== 2'd0) begin
      n_fail++; $display("FAIL reset_flags: bv=%b done=%b err=%b idx=%0d want 0 0 0 0", bit_valid, done, err, bit_idx);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", op_ready); end
    $display("test_reset done");
  endtask

  task automatic test_write;
    logic [3:0] exp_wl [4] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
    issue_op(1'b0, 1'b1, 1'b1, 2'd1, 16'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++; if (WL !== exp_wl[k-1] || WLB !== ~exp_wl[k-1]) begin
        n_fail++; $display("FAIL write_wl T+%0d: got WL=%b WLB=%b want WL=%b", k, WL, WLB, exp_wl[k-1]);
      end
      n_checks++; if (done !== (k == 4) || op_ready !== 1'b0) begin
        n_fail++; $display("FAIL write_ctl T+%0d: got done=%b ready=%b want done=%b ready=0", k, done, op_ready, (k == 4));
      end
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b want 0", err); end
    $display("test_write: WRITE addr=1 done");
  endtask

  task automatic test_read_cs;
    logic [3:0] exp_wl [4] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000};
    issue_op(1'b0, 1'b0, 1'b0, 2'd3, 16'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++; if (WL !== exp_wl[k-1] || done !== (k == 4)) begin
        n_fail++; $display("FAIL read T+%0d: got WL=%b done=%b want WL=%b done=%b", k, WL, done, exp_wl[k-1], (k == 4));
      end
    end
    CS = 1'b0; op_valid = 1'b1; w_en = 1'b1; read_bar = 1'b1; MAC_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (op_ready !== 1'b1 || WL !== 4'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL cs_low cyc%0d: got ready=%b WL=%b done=%b want 1 0000 0", k, op_ready, WL, done);
      end
    end
    op_valid = 1'b0;
    $display("test_read_cs: READ addr=3 then CS=0 hold done");
  endtask

  task automatic test_mac;
    logic [3:0] wl_tab [4] = '{4'b1010, 4'b0110, 4'b1001, 4'b0101};
    logic [3:0] ew;
    int p, ph;
    issue_op(1'b1, 1'b0, 1'b1, 2'd0, 16'hA5C3);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      p = (k - 1) / 3; ph = (k - 1) % 3;
      ew = (k == 13 || ph == 2) ? 4'b0 : wl_tab[p];
      n_checks++; if (WL !== ew || WLB !== ~ew) begin
        n_fail++; $display("FAIL mac_wl T+%0d: got %b want %b", k, WL, ew);
      end
      n_checks++; if (bit_valid !== (k != 13 && ph == 1) || done !== (k == 13)) begin
        n_fail++; $display("FAIL mac_ctl T+%0d: got bv=%b done=%b want bv=%b done=%b", k, bit_valid, done, (k != 13 && ph == 1), (k == 13));
      end
      if (k != 13 && ph == 1) begin
        n_checks++; if (bit_idx !== 2'(3 - p)) begin
          n_fail++; $display("FAIL mac_idx T+%0d: got %0d want %0d", k, bit_idx, 3 - p);
        end
      end
    end
    $display("test_mac: MAC data=A5C3 done");
  endtask

  task automatic test_illegal;
    logic [2:0] enc [4] = '{3'b111, 3'b110, 3'b010, 3'b001};
    for (int i = 0; i < 4; i++) begin
      issue_op(enc[i][2], enc[i][1], enc[i][0], 2'd2, 16'hFFFF);
      @(negedge clk);
      n_checks++; if (done !== 1'b1 || err !== 1'b1 || WL !== 4'b0 || bit_valid !== 1'b0) begin
        n_fail++; $display("FAIL illegal T+1 enc=%b: got done=%b err=%b WL=%b bv=%b want 1 1 0000 0", enc[i], done, err, WL, bit_valid);
      end
      @(negedge clk);
      n_checks++; if (op_ready !== 1'b1 || done !== 1'b0 || err !== 1'b1) begin
        n_fail++; $display("FAIL illegal T+2 enc=%b: got ready=%b done=%b err=%b want 1 0 1", enc[i], op_ready, done, err);
      end
      $display("test_illegal: enc mac/w_en/read_bar=%b done", enc[i]);
    end
    issue_op(1'b0, 1'b1, 1'b1, 2'd0, 16'h0);
    @(negedge clk);
    n_checks++; if (err !== 1'b0 || WL !== 4'b0001) begin
      n_fail++; $display("FAIL illegal_clear: got err=%b WL=%b want 0 0001", err, WL);
    end
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b1 || err !== 1'b0) begin
      n_fail++; $display("FAIL illegal_next_done: got done=%b err=%b want 1 0", done, err);
    end
    $display("test_illegal: following WRITE cleared err");
  endtask

  task automatic test_reset_mid;
    issue_op(1'b1, 1'b0, 1'b1, 2'd0, 16'hA5C3);
    repeat (4) @(negedge clk);
    n_checks++; if (WL !== 4'b0110) begin n_fail++; $display("FAIL midrst_pre: got %b want 0110", WL); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (WL !== 4'b0 || WLB !== 4'b1111 || done !== 1'b0 || op_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_async: got WL=%b WLB=%b done=%b ready=%b want 0000 1111 0 1", WL, WLB, done, op_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || WL !== 4'b0 || op_ready !== 1'b1) begin
        n_fail++; $display("FAIL midrst_after cyc%0d: got done=%b WL=%b ready=%b want 0 0000 1", k, done, WL, op_ready);
      end
    end
    issue_op(1'b0, 1'b0, 1'b0, 2'd2, 16'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++; if (WL !== ((k <= 2) ? 4'b0100 : 4'b0000) || done !== (k == 4)) begin
        n_fail++; $display("FAIL midrst_read T+%0d: got WL=%b done=%b", k, WL, done);
      end
    end
    $display("test_reset_mid: reset during MAC, then READ addr=2 done");
  endtask

  task automatic test_back_to_back;
    issue_op(1'b0, 1'b1, 1'b1, 2'd3, 16'h0);
    repeat (4) @(negedge clk);
    // Request held from the DONE cycle: must not be taken until the following IDLE cycle.
    CS = 1'b1; op_valid = 1'b1; MAC_en = 1'b0; w_en = 1'b0; read_bar = 1'b0; addr = 2'd0;
    @(negedge clk);
    n_checks++; if (op_ready !== 1'b1 || WL !== 4'b0) begin
      n_fail++; $display("FAIL b2b_idle: got ready=%b WL=%b want 1 0000", op_ready, WL);
    end
    @(posedge clk); #1; op_valid = 1'b0; CS = 1'b0;
    @(negedge clk);
    n_checks++; if (WL !== 4'b0001 || op_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got WL=%b ready=%b want 0001 0", WL, op_ready);
    end
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", done); end
    $display("test_back_to_back: WRITE then READ done");
  endtask

  task automatic test_random;
    logic mac, we, rb, ill;
    logic [1:0]  a;
    logic [15:0] d;
    exp_t e;
    int gap;
    for (int i = 0; i < 40; i++) begin
      mac = 1'($urandom); we = 1'($urandom); rb = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin mac = 1'b1; we = 1'b0; end
      a = 2'($urandom); d = 16'($urandom);
      if ($urandom_range(0, 4) == 0) d = d & 16'h3333;
      model_op(mac, we, rb, a, d, ill);
      issue_op(mac, we, rb, a, d);
      for (int k = 0; k < exp_q.size(); k++) begin
        e = exp_q[k];
        @(negedge clk);
        n_checks++; if (WL !== e.wl || WLB !== ~e.wl) begin
          n_fail++; $display("FAIL rnd_wl op%0d T+%0d: got WL=%b WLB=%b want WL=%b", i, k + 1, WL, WLB, e.wl);
        end
        n_checks++; if (bit_valid !== e.bv || done !== e.dn || op_ready !== 1'b0) begin
          n_fail++; $display("FAIL rnd_ctl op%0d T+%0d: got bv=%b done=%b ready=%b want bv=%b done=%b ready=0", i, k + 1, bit_valid, done, op_ready, e.bv, e.dn);
        end
        if (e.bv) begin
          n_checks++; if (bit_idx !== e.bi) begin
            n_fail++; $display("FAIL rnd_idx op%0d T+%0d: got %0d want %0d", i, k + 1, bit_idx, e.bi);
          end
        end
        if (e.dn) begin
          n_checks++; if (err !== ill) begin
            n_fail++; $display("FAIL rnd_err op%0d: got %b want %b", i, err, ill);
          end
        end
`ifdef CIM_ROW_ZSKIP_EN
        n_checks++; if (bit_skip !== e.sk) begin
          n_fail++; $display("FAIL rnd_skip op%0d T+%0d: got %b want %b", i, k + 1, bit_skip, e.sk);
        end
`endif
      end
      $display("rnd op %0d: mac=%b w_en=%b read_bar=%b addr=%0d data=%h illegal=%b cycles=%0d",
               i, mac, we, rb, a, d, ill, exp_q.size());
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        CS = 1'b0; op_valid = 1'($urandom);
        n_checks++; if (WL !== 4'b0 || done !== 1'b0 || op_ready !== 1'b1) begin
          n_fail++; $display("FAIL rnd_idle op%0d: got WL=%b done=%b ready=%b want 0000 0 1", i, WL, done, op_ready);
        end
      end
      op_valid = 1'b0;
    end
  endtask

`ifdef CIM_ROW_ZSKIP_EN
  task automatic test_zskip;
    logic [3:0] ew [9] = '{4'b0, 4'b0, 4'b0101, 4'b0101, 4'b0, 4'b0101, 4'b0101, 4'b0, 4'b0};
    logic       ebv [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    issue_op(1'b1, 1'b0, 1'b1, 2'd0, 16'h0303);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      n_checks++; if (WL !== ew[k-1] || bit_valid !== ebv[k-1] || bit_skip !== (k <= 2) || done !== (k == 9)) begin
        n_fail++; $display("FAIL zskip T+%0d: got WL=%b bv=%b skip=%b done=%b want WL=%b bv=%b skip=%b done=%b",
                           k, WL, bit_valid, bit_skip, done, ew[k-1], ebv[k-1], (k <= 2), (k == 9));
      end
    end
    $display("test_zskip: MAC data=0303 done");
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_cs();
    test_mac();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
`ifdef CIM_ROW_ZSKIP_EN
    test_zskip();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
